// File: rtl/wb_stage.sv
// wb_stage: RV32I writeback stage.
// Aligns/extends load data and issues one registered regfile write per instruction.
module wb_stage #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            mem_valid_i,
    output logic            mem_ready_o,
    input  logic [4:0]      mem_rd_i,
    input  logic            mem_reg_write_i,
    input  logic            mem_is_load_i,
    input  logic [2:0]      mem_funct3_i,
    input  logic [XLEN-1:0] mem_result_i,
    input  logic            dmem_rvalid_i,
    input  logic [XLEN-1:0] dmem_rdata_i,
    output logic [4:0]      rd_o,
    output logic [XLEN-1:0] wd_o,
    output logic            reg_write_o,
    output logic            err_o,
    output logic            busy_o
);

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        WAIT_LOAD = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [4:0]      rd_q, rd_d;
    logic [XLEN-1:0] wd_q, wd_d;
    logic            we_q, we_d;
    logic            err_q, err_d;
    logic [4:0]      ld_rd_q, ld_rd_d;
    logic [2:0]      ld_f3_q, ld_f3_d;
    logic [1:0]      ld_off_q, ld_off_d;
    logic            ld_we_q, ld_we_d;

    logic            accept;
    logic            ld_illegal;
    logic [7:0]      ld_byte;
    logic [15:0]     ld_half;
    logic [XLEN-1:0] ld_data;

    assign mem_ready_o = (state_q != WAIT_LOAD);
    assign busy_o      = (state_q == WAIT_LOAD);
    assign accept      = mem_valid_i && mem_ready_o;
    assign rd_o        = rd_q;
    assign wd_o        = wd_q;
    assign reg_write_o = we_q;
    assign err_o       = err_q;

    // Classify the incoming load as misaligned or unsupported.
    always_comb begin
        ld_illegal = 1'b0;
        case (mem_funct3_i)
            3'b000, 3'b100: ld_illegal = 1'b0;
            3'b001, 3'b101: ld_illegal = mem_result_i[0];
            3'b010:         ld_illegal = |mem_result_i[1:0];
            default:        ld_illegal = 1'b1;
        endcase
    end

    // Select the addressed byte/half of the returned word and extend it.
    always_comb begin
        ld_byte = dmem_rdata_i[{ld_off_q, 3'b000} +: 8];
        ld_half = dmem_rdata_i[{ld_off_q[1], 4'b0000} +: 16];
        ld_data = dmem_rdata_i;
        case (ld_f3_q)
            3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_data = {24'b0, ld_byte};
            3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_data = {16'b0, ld_half};
            default: ld_data = dmem_rdata_i;
        endcase
    end

    // Next-state and registered-output logic; rd/wd only move on a real write.
    always_comb begin
        state_d  = state_q;
        rd_d     = rd_q;
        wd_d     = wd_q;
        we_d     = 1'b0;
        err_d    = 1'b0;
        ld_rd_d  = ld_rd_q;
        ld_f3_d  = ld_f3_q;
        ld_off_d = ld_off_q;
        ld_we_d  = ld_we_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (mem_is_load_i) begin
                        if (ld_illegal) begin
                            err_d = 1'b1;
                        end else begin
                            ld_rd_d  = mem_rd_i;
                            ld_f3_d  = mem_funct3_i;
                            ld_off_d = mem_result_i[1:0];
                            ld_we_d  = mem_reg_write_i;
                            state_d  = WAIT_LOAD;
                        end
                    end else begin
                        we_d = mem_reg_write_i && (mem_rd_i != 5'd0);
                        if (we_d) begin
                            rd_d = mem_rd_i;
                            wd_d = mem_result_i;
                        end
                    end
                end
            end
            WAIT_LOAD: begin
                if (dmem_rvalid_i) begin
                    we_d = ld_we_q && (ld_rd_q != 5'd0);
                    if (we_d) begin
                        rd_d = ld_rd_q;
                        wd_d = ld_data;
                    end
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            rd_q     <= 5'd0;
            wd_q     <= '0;
            we_q     <= 1'b0;
            err_q    <= 1'b0;
            ld_rd_q  <= 5'd0;
            ld_f3_q  <= 3'd0;
            ld_off_q <= 2'd0;
            ld_we_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            rd_q     <= rd_d;
            wd_q     <= wd_d;
            we_q     <= we_d;
            err_q    <= err_d;
            ld_rd_q  <= ld_rd_d;
            ld_f3_q  <= ld_f3_d;
            ld_off_q <= ld_off_d;
            ld_we_q  <= ld_we_d;
        end
    end

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed self-checking bench for wb_stage.
// Inputs change 1ns after each rising edge; outputs are checked there too.
module tb_wb_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid_i;
    logic        mem_ready_o;
    logic [4:0]  mem_rd_i;
    logic        mem_reg_write_i;
    logic        mem_is_load_i;
    logic [2:0]  mem_funct3_i;
    logic [31:0] mem_result_i;
    logic        dmem_rvalid_i;
    logic [31:0] dmem_rdata_i;
    logic [4:0]  rd_o;
    logic [31:0] wd_o;
    logic        reg_write_o;
    logic        err_o;
    logic        busy_o;

    int n_tests = 0;
    int n_fail  = 0;

    wb_stage #(.XLEN(32)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .mem_valid_i     (mem_valid_i),
        .mem_ready_o     (mem_ready_o),
        .mem_rd_i        (mem_rd_i),
        .mem_reg_write_i (mem_reg_write_i),
        .mem_is_load_i   (mem_is_load_i),
        .mem_funct3_i    (mem_funct3_i),
        .mem_result_i    (mem_result_i),
        .dmem_rvalid_i   (dmem_rvalid_i),
        .dmem_rdata_i    (dmem_rdata_i),
        .rd_o            (rd_o),
        .wd_o            (wd_o),
        .reg_write_o     (reg_write_o),
        .err_o           (err_o),
        .busy_o          (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic ld, input logic [2:0] f3,
                         input logic [4:0] rd, input logic we, input logic [31:0] res);
        mem_valid_i     = v;
        mem_is_load_i   = ld;
        mem_funct3_i    = f3;
        mem_rd_i        = rd;
        mem_reg_write_i = we;
        mem_result_i    = res;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        dmem_rvalid_i = 1'b0;
        dmem_rdata_i  = 32'h0;
        #2;
        n_tests++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b exp 0", reg_write_o); end
        n_tests++; if (rd_o !== 5'd0 || wd_o !== 32'h0) begin n_fail++; $display("FAIL reset_rdwd got %0d %h exp 0 0", rd_o, wd_o); end
        n_tests++; if (err_o !== 1'b0 || busy_o !== 1'b0 || mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL reset_ctl got err=%b busy=%b rdy=%b exp 0 0 1", err_o, busy_o, mem_ready_o); end
        #10;
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_alu();
        drive(1'b1, 1'b0, 3'b0, 5'd5, 1'b1, 32'h12345678);
        tick();
        n_tests++; if (reg_write_o !== 1'b1 || rd_o !== 5'd5 || wd_o !== 32'h12345678) begin n_fail++; $display("FAIL alu got we=%b rd=%0d wd=%h exp 1 5 12345678", reg_write_o, rd_o, wd_o); end
        drive(1'b1, 1'b0, 3'b0, 5'd9, 1'b1, 32'hCAFEF00D);
        tick();
        n_tests++; if (reg_write_o !== 1'b1 || rd_o !== 5'd9 || wd_o !== 32'hCAFEF00D) begin n_fail++; $display("FAIL b2b_1 got we=%b rd=%0d wd=%h exp 1 9 cafef00d", reg_write_o, rd_o, wd_o); end
        drive(1'b1, 1'b0, 3'b0, 5'd31, 1'b1, 32'h00000004);
        tick();
        n_tests++; if (reg_write_o !== 1'b1 || rd_o !== 5'd31 || wd_o !== 32'h4) begin n_fail++; $display("FAIL b2b_2 got we=%b rd=%0d wd=%h exp 1 31 4", reg_write_o, rd_o, wd_o); end
        drive(1'b1, 1'b0, 3'b0, 5'd3, 1'b0, 32'h11111111);
        tick();
        n_tests++; if (reg_write_o !== 1'b0 || rd_o !== 5'd31 || wd_o !== 32'h4) begin n_fail++; $display("FAIL nowrite got we=%b rd=%0d wd=%h exp 0 31 4", reg_write_o, rd_o, wd_o); end
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        tick();
    endtask

    task automatic run_load(input string name, input logic [2:0] f3, input logic [1:0] off,
                            input logic [4:0] rd, input int lat, input logic [31:0] rdata,
                            input logic [31:0] exp);
        drive(1'b1, 1'b1, f3, rd, 1'b1, {30'h1000, off});
        tick();
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        n_tests++; if (busy_o !== 1'b1 || mem_ready_o !== 1'b0 || reg_write_o !== 1'b0) begin n_fail++; $display("FAIL %s_wait got busy=%b rdy=%b we=%b exp 1 0 0", name, busy_o, mem_ready_o, reg_write_o); end
        for (int i = 1; i < lat; i++) tick();
        if (lat > 1) begin
            n_tests++; if (busy_o !== 1'b1 || reg_write_o !== 1'b0) begin n_fail++; $display("FAIL %s_hold got busy=%b we=%b exp 1 0", name, busy_o, reg_write_o); end
        end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = rdata;
        tick();
        dmem_rvalid_i = 1'b0;
        n_tests++; if (reg_write_o !== 1'b1 || rd_o !== rd || wd_o !== exp) begin n_fail++; $display("FAIL %s got we=%b rd=%0d wd=%h exp 1 %0d %h", name, reg_write_o, rd_o, wd_o, rd, exp); end
        n_tests++; if (busy_o !== 1'b0 || mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL %s_done got busy=%b rdy=%b exp 0 1", name, busy_o, mem_ready_o); end
        tick();
        n_tests++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL %s_pulse got we=%b exp 0", name, reg_write_o); end
    endtask

    task automatic test_byte_loads();
        run_load("lb3", 3'b000, 2'd3, 5'd10, 3, 32'h80FF7F01, 32'hFFFFFF80);
        run_load("lbu3", 3'b100, 2'd3, 5'd11, 1, 32'h80FF7F01, 32'h00000080);
        run_load("lb1", 3'b000, 2'd1, 5'd12, 2, 32'h80FF7F01, 32'h0000007F);
    endtask

    task automatic test_half_word_loads();
        run_load("lh2", 3'b001, 2'd2, 5'd13, 1, 32'h8001ABCD, 32'hFFFF8001);
        run_load("lhu2", 3'b101, 2'd2, 5'd14, 2, 32'h8001ABCD, 32'h00008001);
        run_load("lh0", 3'b001, 2'd0, 5'd15, 1, 32'h8001ABCD, 32'hFFFFABCD);
        run_load("lw0", 3'b010, 2'd0, 5'd16, 4, 32'h8001ABCD, 32'h8001ABCD);
    endtask

    task automatic test_back_to_back();
        drive(1'b1, 1'b1, 3'b010, 5'd20, 1'b1, 32'h00002000);
        tick();
        drive(1'b1, 1'b0, 3'b0, 5'd21, 1'b1, 32'hA5A5A5A5);
        n_tests++; if (mem_ready_o !== 1'b0) begin n_fail++; $display("FAIL stall_rdy got %b exp 0", mem_ready_o); end
        tick();
        n_tests++; if (reg_write_o !== 1'b0 || busy_o !== 1'b1) begin n_fail++; $display("FAIL stall_hold got we=%b busy=%b exp 0 1", reg_write_o, busy_o); end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h0BADBEEF;
        tick();
        dmem_rvalid_i = 1'b0;
        n_tests++; if (reg_write_o !== 1'b1 || rd_o !== 5'd20 || wd_o !== 32'h0BADBEEF) begin n_fail++; $display("FAIL b2b_load got we=%b rd=%0d wd=%h exp 1 20 0badbeef", reg_write_o, rd_o, wd_o); end
        tick();
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        n_tests++; if (reg_write_o !== 1'b1 || rd_o !== 5'd21 || wd_o !== 32'hA5A5A5A5) begin n_fail++; $display("FAIL b2b_alu got we=%b rd=%0d wd=%h exp 1 21 a5a5a5a5", reg_write_o, rd_o, wd_o); end
        tick();
        n_tests++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL b2b_end got we=%b exp 0", reg_write_o); end
    endtask

    task automatic test_errors();
        drive(1'b1, 1'b1, 3'b010, 5'd6, 1'b1, 32'h00000101);
        tick();
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        n_tests++; if (err_o !== 1'b1 || reg_write_o !== 1'b0) begin n_fail++; $display("FAIL err_lw got err=%b we=%b exp 1 0", err_o, reg_write_o); end
        n_tests++; if (busy_o !== 1'b0 || mem_ready_o !== 1'b1) begin n_fail++; $display("FAIL err_lw_ctl got busy=%b rdy=%b exp 0 1", busy_o, mem_ready_o); end
        tick();
        n_tests++; if (err_o !== 1'b0) begin n_fail++; $display("FAIL err_lw_pulse got %b exp 0", err_o); end
        drive(1'b1, 1'b1, 3'b011, 5'd6, 1'b1, 32'h00000000);
        tick();
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        n_tests++; if (err_o !== 1'b1 || reg_write_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL err_f3 got err=%b we=%b busy=%b exp 1 0 0", err_o, reg_write_o, busy_o); end
        drive(1'b1, 1'b1, 3'b101, 5'd6, 1'b1, 32'h00000003);
        tick();
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        n_tests++; if (err_o !== 1'b1 || busy_o !== 1'b0) begin n_fail++; $display("FAIL err_lhu got err=%b busy=%b exp 1 0", err_o, busy_o); end
        tick();
        n_tests++; if (err_o !== 1'b0 || reg_write_o !== 1'b0) begin n_fail++; $display("FAIL err_end got err=%b we=%b exp 0 0", err_o, reg_write_o); end
    endtask

    task automatic test_rd_zero();
        drive(1'b1, 1'b0, 3'b0, 5'd0, 1'b1, 32'hDEADBEEF);
        tick();
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        n_tests++; if (reg_write_o !== 1'b0 || wd_o === 32'hDEADBEEF) begin n_fail++; $display("FAIL rd0 got we=%b wd=%h exp 0 unchanged", reg_write_o, wd_o); end
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h12121212;
        tick();
        dmem_rvalid_i = 1'b0;
        n_tests++; if (reg_write_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL spurious got we=%b err=%b busy=%b exp 0 0 0", reg_write_o, err_o, busy_o); end
        tick();
        n_tests++; if (reg_write_o !== 1'b0) begin n_fail++; $display("FAIL spurious2 got we=%b exp 0", reg_write_o); end
    endtask

    task automatic test_reset_during_load();
        drive(1'b1, 1'b1, 3'b010, 5'd7, 1'b1, 32'h00000040);
        tick();
        drive(1'b0, 1'b0, 3'b0, 5'd0, 1'b0, 32'h0);
        n_tests++; if (busy_o !== 1'b1) begin n_fail++; $display("FAIL rst_ld_busy got %b exp 1", busy_o); end
        #2;
        rst_n = 1'b0;
        #1;
        n_tests++; if (busy_o !== 1'b0 || mem_ready_o !== 1'b1 || rd_o !== 5'd0 || wd_o !== 32'h0) begin n_fail++; $display("FAIL rst_async got busy=%b rdy=%b rd=%0d wd=%h exp 0 1 0 0", busy_o, mem_ready_o, rd_o, wd_o); end
        tick();
        rst_n = 1'b1;
        tick();
        dmem_rvalid_i = 1'b1;
        dmem_rdata_i  = 32'h77777777;
        tick();
        dmem_rvalid_i = 1'b0;
        n_tests++; if (reg_write_o !== 1'b0 || err_o !== 1'b0 || busy_o !== 1'b0) begin n_fail++; $display("FAIL rst_stale got we=%b err=%b busy=%b exp 0 0 0", reg_write_o, err_o, busy_o); end
        n_tests++; if (rd_o !== 5'd0 || wd_o !== 32'h0) begin n_fail++; $display("FAIL rst_stale_rdwd got rd=%0d wd=%h exp 0 0", rd_o, wd_o); end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_byte_loads();
        test_half_word_loads();
        test_back_to_back();
        test_errors();
        test_rd_zero();
        test_reset_during_load();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_stage.md
# wb_stage

Writeback stage of the RV32I pipeline. It sits between the memory stage and the register file. It accepts retiring instructions over a valid/ready handshake and holds loads until the data-memory response arrives. It aligns and sign/zero-extends load data, then drives one registered write per instruction onto the register file's rd/wd/write-enable inputs.

## Interface
Parameters:
- XLEN, 32, data width; only 32 is supported.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- mem_valid_i  in  1  memory stage presents an instruction.
- mem_ready_o  out  1  stage can accept; combinational, equals (state != WAIT_LOAD).
- mem_rd_i  in  5  destination register.
- mem_reg_write_i  in  1  instruction writes rd.
- mem_is_load_i  in  1  instruction is a load.
- mem_funct3_i  in  3  load type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU.
- mem_result_i  in  32  ALU/PC+4 result for non-loads; load byte address for loads (bits [1:0] used).
- dmem_rvalid_i  in  1  load data valid; single-cycle pulse.
- dmem_rdata_i  in  32  raw aligned word from data memory.
- rd_o  out  5  register-file write address.
- wd_o  out  32  register-file write data.
- reg_write_o  out  1  register-file write enable; one-cycle pulse per write.
- err_o  out  1  one-cycle pulse on a misaligned or illegal load.
- busy_o  out  1  high while in WAIT_LOAD.

## Operation
- FSM states: IDLE, WAIT_LOAD.
- Acceptance occurs on the cycle where mem_valid_i && mem_ready_o.
- IDLE, non-load accepted:
  - Next cycle: rd_o=mem_rd_i, wd_o=mem_result_i, reg_write_o=mem_reg_write_i && (mem_rd_i!=0).
  - Stay in IDLE.
- IDLE, legal load accepted:
  - Latch rd, funct3, addr[1:0], reg_write. Go to WAIT_LOAD.
  - No write is issued that cycle.
- WAIT_LOAD, dmem_rvalid_i=1:
  - Next cycle: reg_write_o=latched reg_write && (rd!=0), wd_o=extended data.
  - Go to IDLE.
- Load extension (b = addr[1:0]):
  - LB: sign-extend rdata[8b+7:8b].
  - LBU: zero-extend rdata[8b+7:8b].
  - LH: sign-extend rdata[16b[1]+15:16b[1]].
  - LHU: zero-extend rdata[16b[1]+15:16b[1]].
  - LW: rdata unchanged.
- Error cases: LH/LHU with addr[0]=1, LW with addr[1:0]!=0, or funct3 in {011,110,111}.
  - No WAIT_LOAD entry and no write.
  - err_o pulses the next cycle; stay in IDLE.
- rd=0: the write is suppressed, but the instruction still retires normally.
- dmem_rvalid_i while in IDLE is ignored; no write, no error.
- mem_valid_i while in WAIT_LOAD is stalled (mem_ready_o=0). The upstream stage holds its inputs.

## Timing
- Reset values (asynchronous on rst_n low): state=IDLE, rd_o=0, wd_o=0, reg_write_o=0, err_o=0, busy_o=0. mem_ready_o=1.
- Reset asserted during WAIT_LOAD discards the pending load. A later rvalid for that load is ignored.
- Non-load latency: reg_write_o rises 1 cycle after acceptance. Throughput is 1 instruction/cycle.
- Load latency: reg_write_o rises 1 cycle after dmem_rvalid_i. The earliest rvalid is 1 cycle after acceptance.
- Earliest next acceptance after a load: the cycle after rvalid. That acceptance's write follows the load's write back-to-back.
- rd_o and wd_o hold their last value when reg_write_o=0.
- reg_write_o and err_o are never both high.

## Test plan
- Reset, then ALU op rd=5, result 0x12345678, reg_write=1 -> next cycle reg_write_o=1, rd_o=5, wd_o=0x12345678. Back-to-back ops write on consecutive cycles.
- LB at addr 0x...3, rvalid 3 cycles later with rdata 0x80FF7F01 -> mem_ready_o=0 and busy_o=1 while waiting. wd_o=0xFFFFFF80 the cycle after rvalid. LBU of the same data gives 0x00000080.
- LH addr[1:0]=2 with rdata 0x8001ABCD -> wd_o=0xFFFF8001. LHU gives 0x00008001. LW addr 0 gives 0x8001ABCD.
- LW addr[1:0]=1, and separately funct3=011 -> err_o pulses once, no reg_write_o, busy_o stays 0, mem_ready_o stays 1.
- ALU op with rd=0, plus a spurious dmem_rvalid_i while in IDLE -> reg_write_o stays 0 throughout.
- Load accepted, rst_n pulsed low before rvalid, then rvalid arrives -> all outputs at reset values, and no write is issued.
